// File: rtl/airlock_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : airlock_pkg                                             |
// | Description: Shared state encoding, step classification, step target |
// |              and command mapping for the craft airlock sequencer.    |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package airlock_pkg;

  // Sequencer states; the numeric value is what appears on stateCode.
  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_A_CLOSE_IN  = 4'd1,
    ST_A_EVAC      = 4'd2,
    ST_A_OPEN_OUT  = 4'd3,
    ST_A_DWELL     = 4'd4,
    ST_A_CLOSE_OUT = 4'd5,
    ST_A_PRESS     = 4'd6,
    ST_A_OPEN_IN   = 4'd7,
    ST_D_CLOSE_IN  = 4'd8,
    ST_D_EVAC      = 4'd9,
    ST_D_OPEN_OUT  = 4'd10,
    ST_D_DWELL     = 4'd11,
    ST_D_CLOSE_OUT = 4'd12,
    ST_DONE        = 4'd13,
    ST_ERROR       = 4'd14
  } state_e;

  // What kind of work a state performs, independent of direction.
  typedef enum logic [2:0] {
    STEP_NONE      = 3'd0,
    STEP_CLOSE_IN  = 3'd1,
    STEP_EVAC      = 3'd2,
    STEP_OPEN_OUT  = 3'd3,
    STEP_CLOSE_OUT = 3'd4,
    STEP_PRESS     = 3'd5,
    STEP_OPEN_IN   = 3'd6,
    STEP_DWELL     = 3'd7
  } step_e;

  // Interlock status bundle, 1 = condition true.
  typedef struct packed {
    logic outer_closed;
    logic inner_closed;
    logic pressurized;
    logic evacuated;
  } ilk_status_t;

  // Interlock command bundle; at most one bit is ever set.
  typedef struct packed {
    logic outer_toggle;
    logic inner_toggle;
    logic pressurize;
    logic evacuate;
  } ilk_cmd_t;

  // Classify a state into the step it performs.
  function automatic step_e step_of(input state_e s);
    step_e st;
    st = STEP_NONE;
    case (s)
      ST_A_CLOSE_IN,  ST_D_CLOSE_IN:  st = STEP_CLOSE_IN;
      ST_A_EVAC,      ST_D_EVAC:      st = STEP_EVAC;
      ST_A_OPEN_OUT,  ST_D_OPEN_OUT:  st = STEP_OPEN_OUT;
      ST_A_DWELL,     ST_D_DWELL:     st = STEP_DWELL;
      ST_A_CLOSE_OUT, ST_D_CLOSE_OUT: st = STEP_CLOSE_OUT;
      ST_A_PRESS:                     st = STEP_PRESS;
      ST_A_OPEN_IN:                   st = STEP_OPEN_IN;
      default:                        st = STEP_NONE;
    endcase
    return st;
  endfunction

  // Successor of a sequence state once its step has completed.
  function automatic state_e next_of(input state_e s);
    state_e n;
    n = ST_IDLE;
    case (s)
      ST_A_CLOSE_IN:  n = ST_A_EVAC;
      ST_A_EVAC:      n = ST_A_OPEN_OUT;
      ST_A_OPEN_OUT:  n = ST_A_DWELL;
      ST_A_DWELL:     n = ST_A_CLOSE_OUT;
      ST_A_CLOSE_OUT: n = ST_A_PRESS;
      ST_A_PRESS:     n = ST_A_OPEN_IN;
      ST_A_OPEN_IN:   n = ST_DONE;
      ST_D_CLOSE_IN:  n = ST_D_EVAC;
      ST_D_EVAC:      n = ST_D_OPEN_OUT;
      ST_D_OPEN_OUT:  n = ST_D_DWELL;
      ST_D_DWELL:     n = ST_D_CLOSE_OUT;
      ST_D_CLOSE_OUT: n = ST_DONE;
      default:        n = ST_IDLE;
    endcase
    return n;
  endfunction

  // True when the interlock already reports the step's goal condition.
  function automatic logic target_met(input step_e st, input ilk_status_t s);
    logic m;
    m = 1'b0;
    case (st)
      STEP_CLOSE_IN:  m = s.inner_closed;
      STEP_EVAC:      m = s.evacuated;
      STEP_OPEN_OUT:  m = ~s.outer_closed;
      STEP_CLOSE_OUT: m = s.outer_closed;
      STEP_PRESS:     m = s.pressurized;
      STEP_OPEN_IN:   m = ~s.inner_closed;
      default:        m = 1'b0;
    endcase
    return m;
  endfunction

  // Command a step issues when its target is not yet met.
  function automatic ilk_cmd_t cmd_of(input step_e st);
    ilk_cmd_t c;
    c = '0;
    case (st)
      STEP_CLOSE_IN, STEP_OPEN_IN:   c.inner_toggle = 1'b1;
      STEP_OPEN_OUT, STEP_CLOSE_OUT: c.outer_toggle = 1'b1;
      STEP_PRESS:                    c.pressurize   = 1'b1;
      STEP_EVAC:                     c.evacuate     = 1'b1;
      default:                       c = '0;
    endcase
    return c;
  endfunction

  // seqBusy is high everywhere except IDLE and ERROR.
  function automatic logic is_busy(input state_e s);
    return (s != ST_IDLE) && (s != ST_ERROR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : seq_timer                                               |
// | Description: Saturating step/dwell cycle counter with synchronous    |
// |              clear and a terminal-count compare output.              |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module seq_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             at_terminal
);

  logic [CNT_W-1:0] count;

  // Count enabled cycles; clear has priority and the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign at_terminal = (count >= terminal);

endmodule
`default_nettype wire

// File: rtl/craft_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : craft_sequencer                                         |
// | Description: Airlock arrival/departure sequencer. Walks a fixed list |
// |              of interlock steps, issuing one command pulse per step  |
// |              when needed, with timeout, dwell, abort and error.      |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module craft_sequencer
  import airlock_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int DWELL_CYCLES   = 500,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arriveReq,
  input  logic       departReq,
  input  logic       abortReq,
  input  logic       clearErr,
  input  logic       outerClosed,
  input  logic       innerClosed,
  input  logic       pressurized,
  input  logic       evacuated,
  input  logic       ilkBusy,
  output logic       cmdOuterToggle,
  output logic       cmdInnerToggle,
  output logic       cmdPressurize,
  output logic       cmdEvacuate,
  output logic       seqBusy,
  output logic       seqDone,
  output logic       seqError,
  output logic [3:0] stateCode
);

  // The timer starts at 0 on the first cycle of a phase, so a phase of N
  // cycles ends when the count reaches N-1.
  localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_TERM   = CNT_W'(DWELL_CYCLES - 1);

  state_e      state;
  state_e      state_nx;
  step_e       step;
  ilk_status_t status;
  ilk_cmd_t    cmd_nx;
  ilk_cmd_t    cmd_q;
  logic        issued;
  logic        issue_now;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        timer_clear;
  logic        timer_en;
  logic        timer_hit;
  logic [CNT_W-1:0] timer_term;

  assign status = {outerClosed, innerClosed, pressurized, evacuated};

  // Timer restarts on every state change and again when a command goes out,
  // so both the pre-issue wait and the response wait are each bounded.
  assign timer_clear = (state_nx != state) || issue_now;
  assign timer_en    = is_busy(state);

  seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (timer_clear),
    .enable      (timer_en),
    .terminal    (timer_term),
    .at_terminal (timer_hit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Per-step issued flag: one command per step, forgotten on leaving it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued <= 1'b0;
    end else if (state_nx != state) begin
      issued <= 1'b0;
    end else if (issue_now) begin
      issued <= 1'b1;
    end
  end

  // Next-state and command decode.
  always_comb begin
    state_nx   = state;
    cmd_nx     = '0;
    issue_now  = 1'b0;
    step       = step_of(state);
    timer_term = (step == STEP_DWELL) ? DWELL_TERM : TIMEOUT_TERM;

    case (state)
      ST_IDLE: begin
        if (arriveReq) begin
          state_nx = ST_A_CLOSE_IN;
        end else if (departReq) begin
          state_nx = ST_D_CLOSE_IN;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      ST_ERROR: begin
        if (clearErr) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        // Abort outranks any completion or timeout in the same cycle.
        if (abortReq) begin
          state_nx = ST_IDLE;
        end else if (step == STEP_DWELL) begin
          if (timer_hit) begin
            state_nx = next_of(state);
          end
        end else if (!issued) begin
          if (target_met(step, status)) begin
            state_nx = next_of(state);
          end else if (timer_hit) begin
            state_nx = ST_ERROR;
          end else if (!ilkBusy) begin
            cmd_nx    = cmd_of(step);
            issue_now = 1'b1;
          end
        end else begin
          if (target_met(step, status) && !ilkBusy) begin
            state_nx = next_of(state);
          end else if (timer_hit) begin
            state_nx = ST_ERROR;
          end
        end
      end
    endcase
  end

  // Output registers, loaded from the decoded next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cmd_q  <= cmd_nx;
      busy_q <= is_busy(state_nx);
      done_q <= (state_nx == ST_DONE);
      err_q  <= (state_nx == ST_ERROR);
    end
  end

  assign cmdOuterToggle = cmd_q.outer_toggle;
  assign cmdInnerToggle = cmd_q.inner_toggle;
  assign cmdPressurize  = cmd_q.pressurize;
  assign cmdEvacuate    = cmd_q.evacuate;
  assign seqBusy        = busy_q;
  assign seqDone        = done_q;
  assign seqError       = err_q;
  assign stateCode      = state;

endmodule
`default_nettype wire

// File: tb/tb_craft_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_craft_sequencer                                      |
// | Description: Self-checking bench for craft_sequencer with a simple   |
// |              interlock plant and a step-list reference model.        |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_craft_sequencer;
  import airlock_pkg::*;

  localparam int TIMEOUT = 2000;
  localparam int DWELL   = 500;
  localparam int CW      = 16;

  localparam int C_OUTER = 1;
  localparam int C_INNER = 2;
  localparam int C_PRESS = 3;
  localparam int C_EVAC  = 4;

  localparam int S_CLOSE_IN  = 0;
  localparam int S_EVAC      = 1;
  localparam int S_OPEN_OUT  = 2;
  localparam int S_DWELL     = 3;
  localparam int S_CLOSE_OUT = 4;
  localparam int S_PRESS     = 5;
  localparam int S_OPEN_IN   = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic arrive_req, depart_req, abort_req, clear_err;
  logic outer_closed, inner_closed, pressurized, evacuated;
  logic plant_busy, force_busy, ilk_busy;
  logic cmd_outer, cmd_inner, cmd_press, cmd_evac;
  logic seq_busy, seq_done, seq_error;
  logic [3:0] state_code;

  assign ilk_busy = plant_busy | force_busy;

  always #5 clk = ~clk;

  craft_sequencer #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .DWELL_CYCLES   (DWELL),
    .CNT_W          (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .arriveReq      (arrive_req),
    .departReq      (depart_req),
    .abortReq       (abort_req),
    .clearErr       (clear_err),
    .outerClosed    (outer_closed),
    .innerClosed    (inner_closed),
    .pressurized    (pressurized),
    .evacuated      (evacuated),
    .ilkBusy        (ilk_busy),
    .cmdOuterToggle (cmd_outer),
    .cmdInnerToggle (cmd_inner),
    .cmdPressurize  (cmd_press),
    .cmdEvacuate    (cmd_evac),
    .seqBusy        (seq_busy),
    .seqDone        (seq_done),
    .seqError       (seq_error),
    .stateCode      (state_code)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int cmd_code_q[$];
  int cmd_cyc_q[$];
  int exp_q[$];
  int done_cnt, multi_cnt, dwell_cnt, first_err_cyc;
  bit plant_en;
  int plant_lat, plant_cnt, pending;

  // Interlock plant effect of one command.
  task automatic apply_cmd(input int code);
    case (code)
      C_OUTER: outer_closed = ~outer_closed;
      C_INNER: inner_closed = ~inner_closed;
      C_PRESS: begin pressurized = 1'b1; evacuated = 1'b0; end
      C_EVAC:  begin evacuated = 1'b1; pressurized = 1'b0; end
      default: ;
    endcase
  endtask

  // Advance one cycle, observe outputs, then let the plant react.
  task automatic tick();
    int n;
    int code;
    @(posedge clk);
    #1;
    cyc++;
    n = int'(cmd_outer) + int'(cmd_inner) + int'(cmd_press) + int'(cmd_evac);
    code = cmd_outer ? C_OUTER : cmd_inner ? C_INNER : cmd_press ? C_PRESS : cmd_evac ? C_EVAC : 0;
    if (n > 1) multi_cnt++;
    if (code != 0) begin
      cmd_code_q.push_back(code);
      cmd_cyc_q.push_back(cyc);
    end
    if (seq_done === 1'b1) done_cnt++;
    if (seq_error === 1'b1 && first_err_cyc < 0) first_err_cyc = cyc;
    if (state_code == ST_A_DWELL || state_code == ST_D_DWELL) dwell_cnt++;
    if (plant_cnt > 0) begin
      plant_cnt--;
      if (plant_cnt == 0) begin
        apply_cmd(pending);
        plant_busy = 1'b0;
      end
    end else if (code != 0 && plant_en) begin
      if (plant_lat == 0) begin
        apply_cmd(code);
      end else begin
        pending    = code;
        plant_cnt  = plant_lat;
        plant_busy = 1'b1;
      end
    end
  endtask

  task automatic clear_log();
    cmd_code_q.delete();
    cmd_cyc_q.delete();
    done_cnt = 0;
    multi_cnt = 0;
    dwell_cnt = 0;
    first_err_cyc = -1;
  endtask

  task automatic set_plant(input bit oc, input bit ic, input bit pr, input bit ev, input int lat);
    outer_closed = oc;
    inner_closed = ic;
    pressurized  = pr;
    evacuated    = ev;
    plant_lat    = lat;
    plant_cnt    = 0;
    plant_busy   = 1'b0;
    plant_en     = 1'b1;
    force_busy   = 1'b0;
  endtask

  // One-cycle request pulse(s).
  task automatic req(input bit a, input bit d, input bit ab, input bit ce);
    arrive_req = a;
    depart_req = d;
    abort_req  = ab;
    clear_err  = ce;
    tick();
    arrive_req = 1'b0;
    depart_req = 1'b0;
    abort_req  = 1'b0;
    clear_err  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state_code == ST_IDLE && seq_busy == 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state_code == st) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Reference model: walk the step list, emitting a command only where the
  // step's goal is not already true, and apply the plant effect.
  task automatic model_sequence(input bit arrival, input bit oc, input bit ic, input bit pr, input bit ev);
    int steps[$];
    exp_q.delete();
    if (arrival) steps = '{S_CLOSE_IN, S_EVAC, S_OPEN_OUT, S_DWELL, S_CLOSE_OUT, S_PRESS, S_OPEN_IN};
    else         steps = '{S_CLOSE_IN, S_EVAC, S_OPEN_OUT, S_DWELL, S_CLOSE_OUT};
    foreach (steps[i]) begin
      case (steps[i])
        S_CLOSE_IN:  if (!ic) begin exp_q.push_back(C_INNER); ic = 1'b1; end
        S_EVAC:      if (!ev) begin exp_q.push_back(C_EVAC);  ev = 1'b1; pr = 1'b0; end
        S_OPEN_OUT:  if (oc)  begin exp_q.push_back(C_OUTER); oc = 1'b0; end
        S_CLOSE_OUT: if (!oc) begin exp_q.push_back(C_OUTER); oc = 1'b1; end
        S_PRESS:     if (!pr) begin exp_q.push_back(C_PRESS); pr = 1'b1; ev = 1'b0; end
        S_OPEN_IN:   if (ic)  begin exp_q.push_back(C_INNER); ic = 1'b0; end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (state_code !== 4'(ST_IDLE)) $display("FAIL reset_state: got %0d expected %0d", state_code, ST_IDLE);
    else passed++;
    checks++;
    if ({cmd_outer, cmd_inner, cmd_press, cmd_evac, seq_busy, seq_done, seq_error} !== 7'b0)
      $display("FAIL reset_outputs: got %b expected %b",
               {cmd_outer, cmd_inner, cmd_press, cmd_evac, seq_busy, seq_done, seq_error}, 7'b0);
    else passed++;
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_arrival();
    bit ok;
    set_plant(1, 1, 1, 0, 5);
    clear_log();
    exp_q = '{C_EVAC, C_OUTER, C_OUTER, C_PRESS, C_INNER};
    req(1, 0, 0, 0);
    checks++;
    if (seq_busy !== 1'b1) $display("FAIL arrival_busy: got %b expected 1", seq_busy);
    else passed++;
    wait_idle(3000, ok);
    checks++;
    if (!ok) $display("FAIL arrival_timeout: got busy expected idle");
    else passed++;
    checks++;
    if (cmd_code_q.size() != exp_q.size()) $display("FAIL arrival_cmd_count: got %0d expected %0d", cmd_code_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < cmd_code_q.size(); i++) begin
      checks++;
      if (cmd_code_q[i] != exp_q[i]) $display("FAIL arrival_cmd[%0d]: got %0d expected %0d", i, cmd_code_q[i], exp_q[i]);
      else passed++;
    end
    checks++;
    if (done_cnt != 1) $display("FAIL arrival_done: got %0d expected 1", done_cnt);
    else passed++;
    checks++;
    if (multi_cnt != 0) $display("FAIL arrival_onehot: got %0d expected 0", multi_cnt);
    else passed++;
  endtask

  task automatic test_departure();
    bit ok;
    set_plant(1, 0, 1, 0, 10);
    clear_log();
    exp_q = '{C_INNER, C_EVAC, C_OUTER, C_OUTER};
    req(0, 1, 0, 0);
    checks++;
    if (state_code !== 4'(ST_D_CLOSE_IN)) $display("FAIL depart_start: got %0d expected %0d", state_code, ST_D_CLOSE_IN);
    else passed++;
    repeat (60) tick();
    req(1, 1, 0, 0);  // must be ignored mid-sequence
    wait_idle(3000, ok);
    checks++;
    if (!ok) $display("FAIL depart_timeout: got busy expected idle");
    else passed++;
    checks++;
    if (cmd_code_q.size() != exp_q.size()) $display("FAIL depart_cmd_count: got %0d expected %0d", cmd_code_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < cmd_code_q.size(); i++) begin
      checks++;
      if (cmd_code_q[i] != exp_q[i]) $display("FAIL depart_cmd[%0d]: got %0d expected %0d", i, cmd_code_q[i], exp_q[i]);
      else passed++;
    end
    checks++;
    if (dwell_cnt != DWELL) $display("FAIL depart_dwell: got %0d expected %0d", dwell_cnt, DWELL);
    else passed++;
    checks++;
    if (done_cnt != 1) $display("FAIL depart_done: got %0d expected 1", done_cnt);
    else passed++;
  endtask

  task automatic test_timeout();
    bit ok;
    int got;
    set_plant(1, 1, 1, 0, 0);
    plant_en = 1'b0;
    clear_log();
    req(0, 1, 0, 0);
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT + 200; i++) begin
      if (seq_error === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    checks++;
    if (!ok) $display("FAIL timeout_reached: got no error expected error");
    else passed++;
    got = (cmd_cyc_q.size() > 0) ? first_err_cyc - cmd_cyc_q[0] : -1;
    checks++;
    if (got != TIMEOUT) $display("FAIL timeout_latency: got %0d expected %0d", got, TIMEOUT);
    else passed++;
    checks++;
    if (cmd_code_q.size() != 1 || cmd_code_q[0] != C_EVAC)
      $display("FAIL timeout_single_cmd: got %0d cmds expected 1 evacuate", cmd_code_q.size());
    else passed++;
    req(1, 0, 0, 0);
    req(0, 1, 0, 0);
    req(0, 0, 1, 0);
    tick();
    checks++;
    if (state_code !== 4'(ST_ERROR) || seq_busy !== 1'b0)
      $display("FAIL error_hold: got state %0d busy %b expected %0d busy 0", state_code, seq_busy, ST_ERROR);
    else passed++;
    req(0, 0, 0, 1);
    checks++;
    if (state_code !== 4'(ST_IDLE) || seq_error !== 1'b0)
      $display("FAIL clear_err: got state %0d err %b expected %0d err 0", state_code, seq_error, ST_IDLE);
    else passed++;
  endtask

  task automatic test_busy_hold();
    bit ok;
    int f;
    int got;
    set_plant(1, 0, 1, 0, 3);
    clear_log();
    force_busy = 1'b1;
    req(0, 1, 0, 0);
    repeat (49) tick();
    force_busy = 1'b0;
    f = cyc;
    checks++;
    if (cmd_code_q.size() != 0) $display("FAIL busy_early_cmd: got %0d cmds expected 0", cmd_code_q.size());
    else passed++;
    tick();
    got = (cmd_cyc_q.size() > 0) ? cmd_cyc_q[0] - f : -1;
    checks++;
    if (got != 1) $display("FAIL busy_release_cmd: got offset %0d expected 1", got);
    else passed++;
    wait_idle(3000, ok);
    checks++;
    if (!ok || done_cnt != 1) $display("FAIL busy_complete: got done %0d expected 1", done_cnt);
    else passed++;
  endtask

  task automatic test_abort();
    bit ok;
    int n;
    set_plant(1, 1, 1, 0, 4);
    clear_log();
    req(1, 0, 0, 0);
    wait_state(4'(ST_A_DWELL), 1000, ok);
    repeat (20) tick();
    req(0, 0, 1, 0);
    checks++;
    if (!ok || state_code !== 4'(ST_IDLE) || seq_busy !== 1'b0)
      $display("FAIL abort_idle: got state %0d busy %b expected %0d busy 0", state_code, seq_busy, ST_IDLE);
    else passed++;
    n = cmd_code_q.size();
    repeat (DWELL + 100) tick();
    checks++;
    if (cmd_code_q.size() != n) $display("FAIL abort_no_cmd: got %0d cmds expected %0d", cmd_code_q.size(), n);
    else passed++;
    checks++;
    if (done_cnt != 0) $display("FAIL abort_no_done: got %0d expected 0", done_cnt);
    else passed++;
  endtask

  task automatic test_both_and_reset();
    bit ok;
    set_plant(1, 1, 1, 0, 30);
    clear_log();
    req(1, 1, 0, 0);
    checks++;
    if (state_code !== 4'(ST_A_CLOSE_IN)) $display("FAIL both_req_arrival: got %0d expected %0d", state_code, ST_A_CLOSE_IN);
    else passed++;
    wait_state(4'(ST_A_PRESS), 3000, ok);
    tick();
    checks++;
    if (!ok || cmd_press !== 1'b1) $display("FAIL press_reached: got press %b expected 1", cmd_press);
    else passed++;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_outer, cmd_inner, cmd_press, cmd_evac, seq_busy, seq_done, seq_error} !== 7'b0 ||
        state_code !== 4'(ST_IDLE))
      $display("FAIL async_reset: got outs %b state %0d expected 0 state %0d",
               {cmd_outer, cmd_inner, cmd_press, cmd_evac, seq_busy, seq_done, seq_error}, state_code, ST_IDLE);
    else passed++;
    repeat (2) tick();
    rst_n = 1'b1;
    clear_log();
    repeat (100) tick();
    checks++;
    if (cmd_code_q.size() != 0 || state_code !== 4'(ST_IDLE))
      $display("FAIL reset_abandon: got %0d cmds state %0d expected 0 cmds state %0d", cmd_code_q.size(), state_code, ST_IDLE);
    else passed++;
  endtask

  task automatic test_random();
    bit ok, oc, ic, pr, ev, arrival;
    int mode, pz;
    for (int it = 0; it < 6; it++) begin
      oc = 1'($urandom_range(0, 1));
      ic = 1'($urandom_range(0, 1));
      pz = $urandom_range(0, 2);
      pr = (pz == 0);
      ev = (pz == 1);
      mode = $urandom_range(0, 2);
      arrival = (mode != 1);
      set_plant(oc, ic, pr, ev, $urandom_range(0, 20));
      model_sequence(arrival, oc, ic, pr, ev);
      clear_log();
      req(mode != 1, mode != 0, 0, 0);
      wait_idle(4000, ok);
      checks++;
      if (!ok) $display("FAIL rand%0d_complete: got busy expected idle", it);
      else passed++;
      checks++;
      if (cmd_code_q.size() != exp_q.size()) $display("FAIL rand%0d_cmd_count: got %0d expected %0d", it, cmd_code_q.size(), exp_q.size());
      else passed++;
      for (int i = 0; i < exp_q.size() && i < cmd_code_q.size(); i++) begin
        checks++;
        if (cmd_code_q[i] != exp_q[i]) $display("FAIL rand%0d_cmd[%0d]: got %0d expected %0d", it, i, cmd_code_q[i], exp_q[i]);
        else passed++;
      end
      checks++;
      if (done_cnt != 1 || multi_cnt != 0 || dwell_cnt != DWELL)
        $display("FAIL rand%0d_stats: got done %0d multi %0d dwell %0d expected 1 0 %0d", it, done_cnt, multi_cnt, dwell_cnt, DWELL);
      else passed++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    arrive_req = 1'b0;
    depart_req = 1'b0;
    abort_req  = 1'b0;
    clear_err  = 1'b0;
    set_plant(1, 1, 1, 0, 5);
    clear_log();
    test_reset();
    test_arrival();
    test_departure();
    test_timeout();
    test_busy_hold();
    test_abort();
    test_both_and_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/craft_sequencer.md
CRAFT_SEQUENCER -- requirements
Module: craft_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2000: max cycles allowed between a command pulse and its status response.
REQ-002 Parameter DWELL_CYCLES, default 500: cycles the outer port stays open for craft transit.
REQ-003 Parameter CNT_W, default 16: width of the shared step/dwell timer.
REQ-004 Clock  in  1  single system clock; all logic on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 arriveReq  in  1  one-cycle pulse: run the arrival sequence.
REQ-007 departReq  in  1  one-cycle pulse: run the departure sequence.
REQ-008 abortReq  in  1  one-cycle pulse: abandon the current sequence.
REQ-009 clearErr  in  1  one-cycle pulse: leave ERROR.
REQ-010 outerClosed, innerClosed, pressurized, evacuated  in  1 each  interlock status, 1 = true.
REQ-011 ilkBusy  in  1  interlock countdown in progress.
REQ-012 cmdOuterToggle, cmdInnerToggle, cmdPressurize, cmdEvacuate  out  1 each  one-cycle command pulses to the interlock.
REQ-013 seqBusy  out  1  high in every state except IDLE and ERROR.
REQ-014 seqDone  out  1  one-cycle pulse on sequence completion.
REQ-015 seqError  out  1  high while in ERROR.
REQ-016 stateCode  out  4  current state encoding.

Function
REQ-017 States SHALL be IDLE, A_CLOSE_IN, A_EVAC, A_OPEN_OUT, A_DWELL, A_CLOSE_OUT, A_PRESS, A_OPEN_IN, D_CLOSE_IN, D_EVAC, D_OPEN_OUT, D_DWELL, D_CLOSE_OUT, DONE, ERROR.
REQ-018 Arrival order SHALL be A_CLOSE_IN -> A_EVAC -> A_OPEN_OUT -> A_DWELL -> A_CLOSE_OUT -> A_PRESS -> A_OPEN_IN -> DONE.
REQ-019 Departure order SHALL be D_CLOSE_IN -> D_EVAC -> D_OPEN_OUT -> D_DWELL -> D_CLOSE_OUT -> DONE.
REQ-020 Step targets: CLOSE_IN innerClosed=1; EVAC evacuated=1; OPEN_OUT outerClosed=0; CLOSE_OUT outerClosed=1; PRESS pressurized=1; OPEN_IN innerClosed=0.
REQ-021 On step entry with target already true, the FSM SHALL advance next cycle with no command pulse.
REQ-022 Otherwise the step's command SHALL pulse for exactly one cycle on the first cycle with ilkBusy=0, and the step issued flag SHALL be set.
REQ-023 Each step SHALL issue at most one command; no re-issue while waiting.
REQ-024 After issue, the timer SHALL count cycles; target true with ilkBusy=0 advances; timer reaching TIMEOUT_CYCLES first SHALL enter ERROR.
REQ-025 Cycles spent waiting for ilkBusy=0 before issue SHALL also be timed against TIMEOUT_CYCLES.
REQ-026 DWELL states SHALL hold exactly DWELL_CYCLES cycles, then advance; no command pulses.
REQ-027 DONE SHALL last one cycle with seqDone=1, then IDLE.
REQ-028 In IDLE, arriveReq SHALL start arrival; departReq starts departure; both same cycle: arrival wins.
REQ-029 arriveReq/departReq outside IDLE SHALL be ignored.
REQ-030 abortReq in any busy state SHALL return to IDLE next cycle, no command pulse, no seqDone; abort wins over same-cycle completion.
REQ-031 ERROR SHALL hold until clearErr (-> IDLE); arrive/depart/abort ignored in ERROR.
REQ-032 Timer SHALL clear on every state change; it SHALL saturate, never wrap.
REQ-033 At most one cmd* output SHALL be high in any cycle.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 Reset low SHALL immediately force IDLE, timer 0, issued flag 0, all cmd* 0, seqBusy 0, seqDone 0, seqError 0, stateCode = IDLE encoding.
REQ-036 Reset mid-sequence SHALL abandon the sequence with no further commands after release.

Structure
REQ-037 State encoding, stateCode values and step-target mapping SHALL live in shared package airlock_pkg.
REQ-038 Timer SHALL be sub-module seq_timer (clear, enable, saturating count, terminal-compare output).

Verification
REQ-039 All closed, pressurized, arriveReq -> cmdInnerToggle skipped, cmdEvacuate, then cmdOuterToggle x2, cmdPressurize, cmdInnerToggle in order; seqDone once.
REQ-040 Inner open, departReq, model responds in 10 cycles -> cmdInnerToggle, cmdEvacuate, cmdOuterToggle, 500-cycle dwell, cmdOuterToggle, seqDone.
REQ-041 Status never responds after cmdEvacuate -> ERROR at exactly 2000 cycles after issue; clearErr -> IDLE.
REQ-042 ilkBusy held 50 cycles on step entry -> command pulses on first cycle after ilkBusy falls, never earlier.
REQ-043 abortReq during A_DWELL -> IDLE next cycle, no further cmd*, seqDone stays 0.
REQ-044 arriveReq and departReq same cycle in IDLE -> arrival path; Reset low mid-A_PRESS -> all outputs 0 immediately.
